// File: rtl/cpu_types_pkg.sv
// Shared CPU/dcache types: MSI coherence state and dcache field widths.
package cpu_types_pkg;

  localparam int DTAG_W = 26;
  localparam int DIDX_W = 3;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_t;

  function automatic logic [31:0] word_sel(input logic [63:0] blk, input logic ofs);
    return ofs ? blk[63:32] : blk[31:0];
  endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Snoop-side bundle: controller snoop inputs, dcache frame lookup and state write port.
interface snoop_responder_if;
  import cpu_types_pkg::*;

  logic                ccwait;
  logic                ccinv;
  logic [31:0]         ccsnoopaddr;
  logic                dwait;
  logic                own_req;
  logic [DIDX_W-1:0]   lk_idx;
  logic [DTAG_W-1:0]   lk_tag0;
  logic [DTAG_W-1:0]   lk_tag1;
  msi_t                lk_st0;
  msi_t                lk_st1;
  logic [63:0]         lk_data0;
  logic [63:0]         lk_data1;
  logic                snp_ccwrite;
  logic [31:0]         snp_dstore;
  logic                snp_busy;
  logic                st_wen;
  logic                st_way;
  logic [DIDX_W-1:0]   st_idx;
  msi_t                st_new;

  modport slave (
    input  ccwait, ccinv, ccsnoopaddr, dwait, own_req,
    input  lk_tag0, lk_tag1, lk_st0, lk_st1, lk_data0, lk_data1,
    output lk_idx, snp_ccwrite, snp_dstore, snp_busy,
    output st_wen, st_way, st_idx, st_new
  );

  modport master (
    output ccwait, ccinv, ccsnoopaddr, dwait, own_req,
    output lk_tag0, lk_tag1, lk_st0, lk_st1, lk_data0, lk_data1,
    input  lk_idx, snp_ccwrite, snp_dstore, snp_busy,
    input  st_wen, st_way, st_idx, st_new
  );

endinterface

// File: rtl/snoop_responder.sv
// Answers bus snoops for a 2-way MSI dcache: flags Modified hits, supplies dirty words,
// then downgrades/invalidates the frame in the cycle after ccwait falls.
module snoop_responder
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  snoop_responder_if.slave  sif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUPPLY  = 2'd1,
    WAITEND = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_way;
  logic               r_hit;
  logic               r_hitm;
  logic               r_inv;
  msi_t               r_st;
  logic [DIDX_W-1:0]  r_idx;
  logic [1:0]         r_wcnt;

  logic [DTAG_W-1:0]  w_tag;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_hit;
  logic               w_hitm;
  logic               w_way;
  msi_t               w_st;
  logic               w_act;
  logic               w_cap;
  logic               w_ccwrite;
  logic [31:0]        w_dstore;
  logic               w_wen;
  logic               w_st_way;
  logic [DIDX_W-1:0]  w_st_idx;
  msi_t               w_st_new;

  assign w_tag      = sif.ccsnoopaddr[31:6];
  assign sif.lk_idx = sif.ccsnoopaddr[5:3];

  assign w_hit0 = (sif.lk_tag0 == w_tag) && (sif.lk_st0 != MSI_I);
  assign w_hit1 = (sif.lk_tag1 == w_tag) && (sif.lk_st1 != MSI_I);
  assign w_hit  = w_hit0 | w_hit1;
  assign w_way  = w_hit1;
  assign w_st   = w_hit1 ? sif.lk_st1 : sif.lk_st0;
  assign w_hitm = w_hit && (w_st == MSI_M);

  // Reset gates the combinational responses so nothing leaks out while nRST is low.
  assign w_act = sif.ccwait & ~sif.own_req & nRST;

  always_comb begin
    w_next    = r_state;
    w_cap     = 1'b0;
    w_ccwrite = 1'b0;
    w_dstore  = 32'd0;
    w_wen     = 1'b0;
    w_st_way  = 1'b0;
    w_st_idx  = '0;
    w_st_new  = MSI_I;
    case (r_state)
      IDLE: begin
        w_ccwrite = w_act & w_hitm;
        if (w_act) begin
          w_cap  = 1'b1;
          w_next = w_hitm ? SUPPLY : WAITEND;
        end
      end
      SUPPLY: begin
        // Only the first two transferred words are ours to drive.
        if (!r_wcnt[1]) begin
          w_ccwrite = 1'b1;
          w_dstore  = word_sel(r_way ? sif.lk_data1 : sif.lk_data0, sif.ccsnoopaddr[2]);
        end
        if (!sif.ccwait) w_next = UPDATE;
      end
      WAITEND: begin
        if (!sif.ccwait) w_next = r_hit ? UPDATE : IDLE;
      end
      UPDATE: begin
        w_wen    = 1'b1;
        w_st_way = r_way;
        w_st_idx = r_idx;
        w_st_new = r_inv ? MSI_I : (r_hitm ? MSI_S : r_st);
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_way   <= 1'b0;
      r_hit   <= 1'b0;
      r_hitm  <= 1'b0;
      r_inv   <= 1'b0;
      r_st    <= MSI_I;
      r_idx   <= '0;
      r_wcnt  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_cap) begin
        r_way  <= w_way;
        r_hit  <= w_hit;
        r_hitm <= w_hitm;
        r_inv  <= sif.ccinv;
        r_st   <= w_st;
        r_idx  <= sif.lk_idx;
        r_wcnt <= 2'd0;
      end else begin
        if (r_state == WAITEND && sif.ccinv) r_inv <= 1'b1;
        if (r_state == SUPPLY && !sif.dwait && !r_wcnt[1]) r_wcnt <= r_wcnt + 2'd1;
      end
    end
  end

  assign sif.snp_ccwrite = w_ccwrite;
  assign sif.snp_dstore  = w_dstore;
  assign sif.snp_busy    = (r_state != IDLE) | w_act;
  assign sif.st_wen      = w_wen;
  assign sif.st_way      = w_st_way;
  assign sif.st_idx      = w_st_idx;
  assign sif.st_new      = w_st_new;

endmodule

// File: tb/tb_snoop_responder.sv
// Bench for snoop_responder: directed snoop scenarios plus randomized transactions
// checked against a transaction-level MSI model of the 2-way frame array.
module tb_snoop_responder;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  snoop_responder_if bus();

  snoop_responder dut (
    .CLK  (CLK),
    .nRST (nRST),
    .sif  (bus)
  );

  logic [DTAG_W-1:0] m_tag [0:7][0:1];
  msi_t              m_st  [0:7][0:1];
  logic [63:0]       m_dat [0:7][0:1];

  assign bus.lk_tag0  = m_tag[bus.lk_idx][0];
  assign bus.lk_tag1  = m_tag[bus.lk_idx][1];
  assign bus.lk_st0   = m_st[bus.lk_idx][0];
  assign bus.lk_st1   = m_st[bus.lk_idx][1];
  assign bus.lk_data0 = m_dat[bus.lk_idx][0];
  assign bus.lk_data1 = m_dat[bus.lk_idx][1];

  logic [40:0] obs;
  assign obs = {bus.snp_ccwrite, bus.snp_dstore, bus.snp_busy, bus.st_wen,
                bus.st_way, bus.st_idx, bus.st_new};

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [40:0] ex(input logic ccw, input logic [31:0] d, input logic busy,
                                     input logic wen, input logic way, input logic [2:0] idx,
                                     input logic [1:0] nw);
    return {ccw, d, busy, wen, way, idx, nw};
  endfunction

  task automatic chk(input string tag, input logic [40:0] expv);
    n_cmp++;
    assert (obs === expv)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  task automatic chk_idx(input string tag, input logic [2:0] expv);
    n_cmp++;
    assert (bus.lk_idx === expv)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, bus.lk_idx, expv);
      end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One snoop: ccwait high for n_hi cycles, then low; low_mask bit c = dwait low in cycle c.
  task automatic run_txn(input string tag, input logic [2:0] idx, input logic [25:0] tag_a,
                         input logic inv, input logic own, input int n_hi,
                         input logic [15:0] low_mask);
    logic [31:0] addr;
    int          hw;
    logic        h;
    logic        hm;
    int          cnt;
    logic [1:0]  nw;
    logic        ccw;
    logic [31:0] d;
    addr = {tag_a, idx, 3'b000};
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (m_tag[idx][w] == tag_a && m_st[idx][w] != MSI_I) hw = w;
    h  = (hw >= 0) && !own;
    hm = h && (m_st[idx][hw] == MSI_M);
    nw = 2'd0;
    if (h) nw = inv ? MSI_I : (hm ? MSI_S : m_st[idx][hw]);
    cnt = 0;
    for (int c = 0; c <= n_hi + 2; c++) begin
      bus.ccwait      = (c < n_hi);
      bus.ccinv       = (c < n_hi) ? inv : 1'b0;
      bus.own_req     = (c < n_hi) ? own : 1'b0;
      bus.dwait       = (c == 0) ? 1'b1 : ~low_mask[c];
      bus.ccsnoopaddr = addr | ((cnt >= 1) ? 32'd4 : 32'd0);
      @(negedge CLK);
      if (c == 0) begin
        chk({tag, ".snoop"}, ex(hm, 32'd0, !own, 1'b0, 1'b0, 3'd0, 2'd0));
        chk_idx({tag, ".lk_idx"}, idx);
      end else if (c <= n_hi) begin
        ccw = hm && (cnt < 2);
        d   = ccw ? m_dat[idx][hw][32*cnt +: 32] : 32'd0;
        chk($sformatf("%s.c%0d", tag, c), ex(ccw, d, !own, 1'b0, 1'b0, 3'd0, 2'd0));
      end else if (c == n_hi + 1 && h) begin
        chk({tag, ".update"}, ex(1'b0, 32'd0, 1'b1, 1'b1, hw[0], idx, nw));
      end else begin
        chk($sformatf("%s.quiet%0d", tag, c), ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
      end
      if (hm && c >= 1 && c <= n_hi && !bus.dwait && cnt < 2) cnt++;
      tick();
    end
    if (h) m_st[idx][hw] = msi_t'(nw);
  endtask

  initial begin
    logic [2:0]  r_idx;
    logic [25:0] r_tag;
    int          scen;
    int          way;
    int          nh;
    logic [15:0] mask;
    int          lows;

    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 2; w++) begin
        m_tag[i][w] = 26'h3FFFFFF;
        m_st[i][w]  = MSI_I;
        m_dat[i][w] = 64'd0;
      end
    bus.ccwait = 1'b1; bus.ccinv = 1'b0; bus.dwait = 1'b1; bus.own_req = 1'b0;
    bus.ccsnoopaddr = 32'h48;
    m_tag[1][1] = 26'd1; m_st[1][1] = MSI_M;

    // Reset held with ccwait high and a Modified frame under the address.
    tick(); tick();
    @(negedge CLK);
    chk("reset", ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
    tick();
    bus.ccwait = 1'b0;
    nRST = 1'b1;
    tick();

    // BusRd to a Modified block in way 1.
    m_tag[1][0] = 26'd9; m_st[1][0] = MSI_S;
    m_dat[1][1] = {32'hCAFEF00D, 32'hDEADBEEF};
    run_txn("busrd_m", 3'd1, 26'd1, 1'b0, 1'b0, 3, 16'b0000_0000_0000_0110);

    // BusRdX to a Shared block in way 0.
    m_tag[2][0] = 26'd3; m_st[2][0] = MSI_S; m_dat[2][0] = 64'h1111_2222_3333_4444;
    m_tag[2][1] = 26'd4; m_st[2][1] = MSI_M;
    run_txn("busrdx_s", 3'd2, 26'd3, 1'b1, 1'b0, 4, 16'b0000_0000_0000_1010);

    // Miss: tags 5/6 against snooped tag 1.
    m_tag[3][0] = 26'd5; m_st[3][0] = MSI_M;
    m_tag[3][1] = 26'd6; m_st[3][1] = MSI_S;
    run_txn("miss", 3'd3, 26'd1, 1'b1, 1'b0, 3, 16'd0);

    // Local dcache is the requester: snoop ignored even on a Modified hit.
    m_tag[4][1] = 26'd7; m_st[4][1] = MSI_M; m_dat[4][1] = 64'h5555_6666_7777_8888;
    run_txn("own_req", 3'd4, 26'd7, 1'b0, 1'b1, 3, 16'b0000_0000_0000_0110);

    // Single-cycle ccwait pulses.
    m_tag[5][0] = 26'd2; m_st[5][0] = MSI_S;
    run_txn("pulse_s", 3'd5, 26'd2, 1'b0, 1'b0, 1, 16'd0);
    run_txn("pulse_miss", 3'd5, 26'd8, 1'b0, 1'b0, 1, 16'd0);

    // Reset while supplying the second word of a Modified block.
    m_st[1][1] = MSI_M;
    bus.ccwait = 1'b1; bus.ccinv = 1'b0; bus.own_req = 1'b0; bus.dwait = 1'b1;
    bus.ccsnoopaddr = 32'h48;
    @(negedge CLK);
    chk("rstmid.snoop", ex(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0));
    tick();
    bus.dwait = 1'b0;
    @(negedge CLK);
    chk("rstmid.word0", ex(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0));
    tick();
    bus.ccsnoopaddr = 32'h4C; bus.dwait = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    chk("rstmid.async", ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
    tick();
    bus.ccwait = 1'b0;
    tick();
    nRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("rstmid.after%0d", c), ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
      tick();
    end

    // Randomized snoops: miss / invalid-tag-match / Shared hit / Modified hit.
    for (int t = 0; t < 40; t++) begin
      r_idx = 3'($urandom_range(0, 7));
      r_tag = 26'($urandom);
      scen  = $urandom_range(0, 3);
      way   = $urandom_range(0, 1);
      m_tag[r_idx][0] = r_tag + 26'd1;
      m_tag[r_idx][1] = r_tag + 26'd2;
      m_st[r_idx][0]  = msi_t'(2'($urandom_range(0, 2)));
      m_st[r_idx][1]  = msi_t'(2'($urandom_range(0, 2)));
      m_dat[r_idx][0] = {$urandom, $urandom};
      m_dat[r_idx][1] = {$urandom, $urandom};
      if (scen == 1) begin
        m_tag[r_idx][way] = r_tag; m_st[r_idx][way] = MSI_I;
      end else if (scen == 2) begin
        m_tag[r_idx][way] = r_tag; m_st[r_idx][way] = MSI_S;
      end else if (scen == 3) begin
        m_tag[r_idx][way] = r_tag; m_st[r_idx][way] = MSI_M;
      end
      nh   = $urandom_range(3, 6);
      mask = 16'($urandom);
      lows = 0;
      for (int b = 1; b <= nh; b++) lows += int'(mask[b]);
      if (lows < 2) begin
        mask[1]  = 1'b1;
        mask[nh] = 1'b1;
      end
      run_txn($sformatf("rnd%0d", t), r_idx, r_tag, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), nh, mask);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
